// File: rtl/counter_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : counter_bus_pkg
// Purpose : Shared definitions for the counter bus controller: command
//           opcode encodings, FSM state enumeration and settle counter width.
// Revision: 1.0 - initial release
// ============================================================================
package counter_bus_pkg;

  // Command opcodes carried on cmd_op_i
  localparam logic [1:0] OP_NOP        = 2'b00;
  localparam logic [1:0] OP_LOAD       = 2'b01;
  localparam logic [1:0] OP_READ       = 2'b10;
  localparam logic [1:0] OP_READ_DELTA = 2'b11;

  // Width of the bus-settle down-counter (SETTLE_CYCLES legal range 1..15)
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/counter_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_bus_ctrl
// Purpose : Bus-side initiator for an 8-bit loadable counter. Accepts
//           LOAD / READ / READ_DELTA commands, sequences the counter's
//           load-enable and output-enable pins with a programmable settle
//           delay, samples the returned count and responds with either the
//           raw count or the delta from the previous reference value.
// Ports   : clk, rst            - clock, async active-high reset
//           cmd_valid_i/ready_o - command handshake; cmd_op_i, cmd_data_i
//           load_e_o, load_val_o, out_e_o - counter pin drivers
//           bus_data_i          - counter output bus
//           rsp_valid_o/ready_i - response handshake; rsp_data_o, rsp_wrap_o
// Revision: 1.0 - initial release
// ============================================================================
module counter_bus_ctrl #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              load_e_o,
  output logic [DATA_W-1:0] load_val_o,
  output logic              out_e_o,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_wrap_o
);
  import counter_bus_pkg::*;

  // DRIVE lasts SETTLE_CYCLES cycles: counter is preloaded with S-1 and
  // DRIVE exits when it reaches zero.
  localparam logic [SETTLE_W-1:0] C_SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                delta_q, delta_d;
  logic [DATA_W-1:0]   load_val_q, load_val_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   ref_q, ref_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_wrap_q, rsp_wrap_d;
  logic                load_e_q, load_e_d;
  logic                out_e_q, out_e_d;
  logic                rsp_valid_q, rsp_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      delta_q     <= 1'b0;
      load_val_q  <= '0;
      sample_q    <= '0;
      ref_q       <= '0;
      rsp_data_q  <= '0;
      rsp_wrap_q  <= 1'b0;
      load_e_q    <= 1'b0;
      out_e_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      delta_q     <= delta_d;
      load_val_q  <= load_val_d;
      sample_q    <= sample_d;
      ref_q       <= ref_d;
      rsp_data_q  <= rsp_data_d;
      rsp_wrap_q  <= rsp_wrap_d;
      load_e_q    <= load_e_d;
      out_e_q     <= out_e_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    delta_d    = delta_q;
    load_val_d = load_val_q;
    sample_d   = sample_q;
    ref_d      = ref_q;
    rsp_data_d = rsp_data_q;
    rsp_wrap_d = rsp_wrap_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_i)
            OP_LOAD: begin
              state_d    = ST_LOAD;
              load_val_d = cmd_data_i;
              ref_d      = cmd_data_i;
            end
            OP_READ, OP_READ_DELTA: begin
              state_d  = ST_DRIVE;
              settle_d = C_SETTLE_LOAD;
              delta_d  = (cmd_op_i == OP_READ_DELTA);
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_DRIVE: begin
        if (settle_q == '0) state_d = ST_SAMPLE;
        else                settle_d = settle_q - 1'b1;
      end
      ST_SAMPLE: begin
        // Response fields are formed from the bus value at capture time so
        // they are already registered when rsp_valid rises.
        sample_d   = bus_data_i;
        rsp_data_d = delta_q ? (bus_data_i - ref_q) : bus_data_i;
        rsp_wrap_d = (bus_data_i < ref_q);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          ref_d   = sample_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin/handshake outputs are registered images of the next state, so
    // load_e and out_e are mutually exclusive by construction.
    load_e_d    = (state_d == ST_LOAD);
    out_e_d     = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign load_e_o    = load_e_q;
  assign load_val_o  = load_val_q;
  assign out_e_o     = out_e_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_wrap_o  = rsp_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_bus_ctrl
// Purpose : Self-checking bench for counter_bus_ctrl. Two instances share the
//           command/response stimulus: one with the default settle of 1 and
//           one with a settle of 4. A bus model drives a chosen value only
//           while out_e is high.
// Revision: 1.0 - initial release
// ============================================================================
module tb_counter_bus_ctrl;

  localparam logic [1:0] C_NOP = 2'b00, C_LOAD = 2'b01, C_READ = 2'b10, C_RDD = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_ready = 1'b0;
  logic [7:0] model = 8'h00;

  logic       cmd_ready_a, load_e_a, out_e_a, rsp_valid_a, rsp_wrap_a;
  logic [7:0] load_val_a, rsp_data_a, bus_a;
  logic       cmd_ready_b, load_e_b, out_e_b, rsp_valid_b, rsp_wrap_b;
  logic [7:0] load_val_b, rsp_data_b, bus_b;

  assign bus_a = out_e_a ? model : 8'h00;
  assign bus_b = out_e_b ? model : 8'h00;

  always #5 clk = ~clk;

  counter_bus_ctrl #(.DATA_W(8), .SETTLE_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_a),
    .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .load_e_o(load_e_a),
    .load_val_o(load_val_a), .out_e_o(out_e_a), .bus_data_i(bus_a),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data_a), .rsp_wrap_o(rsp_wrap_a));

  counter_bus_ctrl #(.DATA_W(8), .SETTLE_CYCLES(4)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_b),
    .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .load_e_o(load_e_b),
    .load_val_o(load_val_b), .out_e_o(out_e_b), .bus_data_i(bus_b),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data_b), .rsp_wrap_o(rsp_wrap_b));

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] model;
    logic [7:0] exp_data;
    logic       exp_wrap;
    int         stall;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " out_e_a"}, {31'd0, out_e_a}, 0);
    chk({tag, " out_e_b"}, {31'd0, out_e_b}, 0);
    chk({tag, " load_e_a"}, {31'd0, load_e_a}, 0);
    chk({tag, " rsp_valid_a"}, {31'd0, rsp_valid_a}, 0);
    chk({tag, " rsp_valid_b"}, {31'd0, rsp_valid_b}, 0);
    chk({tag, " rsp_wrap_a"}, {31'd0, rsp_wrap_a}, 0);
    chk({tag, " load_val_a"}, {24'd0, load_val_a}, 0);
    chk({tag, " rsp_data_a"}, {24'd0, rsp_data_a}, 0);
    chk({tag, " cmd_ready_a"}, {31'd0, cmd_ready_a}, 1);
    chk({tag, " cmd_ready_b"}, {31'd0, cmd_ready_b}, 1);
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    int    lat_a, lat_b, oe_a, oe_b, le_a, le_b, lim;
    bit    is_rd, ovl;
    string t;
    v     = vecs[i];
    is_rd = v.op[1];
    t     = $sformatf("v%0d", i);
    lat_a = -1; lat_b = -1; oe_a = 0; oe_b = 0; le_a = 0; le_b = 0; ovl = 1'b0;
    lim   = is_rd ? 12 : 4;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; model = v.model;
    @(posedge clk); #1;
    // Scramble command inputs after acceptance; they must be ignored now.
    cmd_valid = 1'b0; cmd_op = C_LOAD; cmd_data = 8'hC3;
    chk({t, " cmd_ready_a after accept"}, {31'd0, cmd_ready_a}, {31'd0, v.op == C_NOP});
    chk({t, " cmd_ready_b after accept"}, {31'd0, cmd_ready_b}, {31'd0, v.op == C_NOP});
    if (v.op == C_LOAD) begin
      chk({t, " load_val_a"}, {24'd0, load_val_a}, {24'd0, v.data});
      chk({t, " load_val_b"}, {24'd0, load_val_b}, {24'd0, v.data});
    end

    for (int c = 0; c <= lim; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (out_e_a)  oe_a++;
      if (out_e_b)  oe_b++;
      if (load_e_a) le_a++;
      if (load_e_b) le_b++;
      if ((load_e_a & out_e_a) | (load_e_b & out_e_b)) ovl = 1'b1;
      if (rsp_valid_a && lat_a < 0) lat_a = c;
      if (rsp_valid_b && lat_b < 0) lat_b = c;
      if (is_rd && lat_a >= 0 && lat_b >= 0) break;
    end

    chk({t, " out_e_a cycles"}, oe_a, is_rd ? 2 : 0);
    chk({t, " out_e_b cycles"}, oe_b, is_rd ? 5 : 0);
    chk({t, " load_e_a cycles"}, le_a, (v.op == C_LOAD) ? 1 : 0);
    chk({t, " load_e_b cycles"}, le_b, (v.op == C_LOAD) ? 1 : 0);
    chk({t, " load/out overlap"}, {31'd0, ovl}, 0);

    if (is_rd) begin
      chk({t, " latency_a"}, lat_a, 2);
      chk({t, " latency_b"}, lat_b, 5);
      chk({t, " rsp_data_a"}, {24'd0, rsp_data_a}, {24'd0, v.exp_data});
      chk({t, " rsp_wrap_a"}, {31'd0, rsp_wrap_a}, {31'd0, v.exp_wrap});
      chk({t, " rsp_data_b"}, {24'd0, rsp_data_b}, {24'd0, v.exp_data});
      chk({t, " rsp_wrap_b"}, {31'd0, rsp_wrap_b}, {31'd0, v.exp_wrap});
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = C_READ; model = 8'hEE;
        @(posedge clk); #1;
        chk({t, " stall rsp_valid_a"}, {31'd0, rsp_valid_a}, 1);
        chk({t, " stall rsp_data_a"}, {24'd0, rsp_data_a}, {24'd0, v.exp_data});
        chk({t, " stall rsp_wrap_a"}, {31'd0, rsp_wrap_a}, {31'd0, v.exp_wrap});
        chk({t, " stall cmd_ready_a"}, {31'd0, cmd_ready_a}, 0);
        chk({t, " stall out_e_a"}, {31'd0, out_e_a}, 0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      chk({t, " post-hs rsp_valid_a"}, {31'd0, rsp_valid_a}, 0);
      chk({t, " post-hs rsp_valid_b"}, {31'd0, rsp_valid_b}, 0);
      chk({t, " post-hs cmd_ready_a"}, {31'd0, cmd_ready_a}, 1);
      chk({t, " post-hs out_e_a"}, {31'd0, out_e_a}, 0);
    end else begin
      chk({t, " no rsp_a"}, lat_a, 32'hFFFF_FFFF);
      chk({t, " no rsp_b"}, lat_b, 32'hFFFF_FFFF);
      chk({t, " cmd_ready_a idle"}, {31'd0, cmd_ready_a}, 1);
    end
  endtask

  initial begin
    bit seen;
    //                op      data   model  exp    wrap stall
    vecs[0] = '{C_READ, 8'h00, 8'h37, 8'h37, 1'b0, 0};
    vecs[1] = '{C_LOAD, 8'h5A, 8'h00, 8'h00, 1'b0, 0};
    vecs[2] = '{C_LOAD, 8'hF0, 8'h00, 8'h00, 1'b0, 0};
    vecs[3] = '{C_RDD,  8'h00, 8'h05, 8'h15, 1'b1, 0};
    vecs[4] = '{C_RDD,  8'h00, 8'h08, 8'h03, 1'b0, 5};
    vecs[5] = '{C_NOP,  8'hAA, 8'h00, 8'h00, 1'b0, 0};
    vecs[6] = '{C_READ, 8'h00, 8'hFF, 8'hFF, 1'b0, 0};
    vecs[7] = '{C_RDD,  8'h00, 8'h00, 8'h01, 1'b1, 0};
    vecs[8] = '{C_LOAD, 8'h10, 8'h00, 8'h00, 1'b0, 0};
    vecs[9] = '{C_RDD,  8'h00, 8'h10, 8'h00, 1'b0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset pulsed while in DRIVE drops the transaction
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_READ; model = 8'h37;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("middrive out_e_a before rst", {31'd0, out_e_a}, 1);
    chk("middrive out_e_b before rst", {31'd0, out_e_b}, 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("middrive");
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid_a | rsp_valid_b | out_e_a | out_e_b) seen = 1'b1;
    end
    chk("middrive no activity after rst", {31'd0, seen}, 0);
    chk("middrive cmd_ready_a", {31'd0, cmd_ready_a}, 1);

    for (int i = 0; i < 10; i++) run_vec(i);

    // load_val holds the last LOAD value outside LOAD
    chk("load_val_a hold", {24'd0, load_val_a}, 32'h10);
    chk("load_val_b hold", {24'd0, load_val_b}, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/counter_bus_ctrl.md
# counter_bus_ctrl

Bus-side controller for the 8-bit loadable counter: the initiator that drives the counter's load-enable, output-enable and load-value pins and reads back its output bus. It accepts LOAD/READ commands over a valid/ready handshake, sequences the counter's pins with a programmable bus-settle delay, samples the returned count, and returns it (or the delta since the previous read) over a response handshake. It sits between on-chip control logic and the counter's pin-level interface.

## Interface
- DATA_W, 8 — counter/bus width
- SETTLE_CYCLES, 1 — cycles out_e is held before sampling; legal 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept command
- cmd_op  in  2  00 NOP, 01 LOAD, 10 READ, 11 READ_DELTA
- cmd_data  in  DATA_W  load value (LOAD only)
- load_e  out  1  counter load enable
- load_val  out  DATA_W  counter load value
- out_e  out  1  counter output enable
- bus_data  in  DATA_W  counter output bus
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  sampled count or delta
- rsp_wrap  out  1  sample < previous reference value

## Operation
- FSM states: IDLE, LOAD, DRIVE, SAMPLE, RESP.
- cmd_ready = 1 only in IDLE (combinational on state); acceptance = cmd_valid & cmd_ready at a rising edge.
- NOP: accepted, stays IDLE, no pin activity, no response.
- LOAD: -> LOAD for exactly one cycle with load_e=1, load_val=cmd_data; -> IDLE. ref_q <= cmd_data. No response.
- READ / READ_DELTA: -> DRIVE (out_e=1), settle counter counts SETTLE_CYCLES cycles -> SAMPLE (out_e=1) -> bus_data captured into sample_q at end of SAMPLE -> RESP.
- RESP: rsp_valid=1; rsp_data = sample_q (READ) or sample_q - ref_q mod 2^DATA_W (READ_DELTA); rsp_wrap = (sample_q < ref_q), unsigned. Held stable until rsp_valid & rsp_ready, then ref_q <= sample_q, -> IDLE.
- load_val registered; holds last LOAD value outside LOAD state; load_e and out_e never high in the same cycle.
- cmd_op, cmd_data sampled only at acceptance; ignored otherwise.
- Reset (any state, including mid-DRIVE or RESP): state IDLE; load_e, out_e, rsp_valid, rsp_wrap = 0; load_val, rsp_data, sample_q, ref_q, settle counter = 0. Transaction in flight is dropped, no response.

## Timing
- LOAD accepted at edge E0: load_e=1 between E0 and E1; counter loads at E1; cmd_ready high again after E1.
- READ accepted at E0: out_e=1 from E0 to E(S+1), S=SETTLE_CYCLES (S+1 cycles total); bus_data sampled at E(S+1); rsp_valid=1 after E(S+1). Default S=1: response 2 cycles after acceptance.
- Response handshake completes at edge with rsp_valid & rsp_ready; earliest next acceptance is the following edge (cmd_ready rises after handshake edge). Back-to-back READ throughput with rsp_ready tied high: one per S+3 cycles.
- All outputs registered except cmd_ready.

## Structure
- Shared package counter_bus_pkg: cmd_op encoding constants (OP_NOP/OP_LOAD/OP_READ/OP_READ_DELTA), FSM state enum, SETTLE counter width (4).
- Single module, no sub-module; FSM plus settle counter, sample/reference registers and one subtractor.

## Test plan
- Reset mid-DRIVE (rst pulsed in DRIVE) -> out_e drops asynchronously, rsp_valid never asserts, all outputs 0, cmd_ready=1 after release.
- LOAD 0x5A -> load_e=1 for exactly one cycle with load_val=0x5A, no rsp_valid; cmd_ready low for that cycle only.
- Bus model drives 0x37 only while out_e=1, S=1: READ -> out_e high 2 cycles, rsp_valid 2 cycles after acceptance, rsp_data=0x37, rsp_wrap=0.
- LOAD 0xF0, model returns 0x05, READ_DELTA -> rsp_data=0x15, rsp_wrap=1; next READ_DELTA returning 0x08 -> rsp_data=0x03, rsp_wrap=0.
- rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_valid with READ not accepted until after handshake.
- SETTLE_CYCLES=4 build -> out_e high exactly 5 cycles per READ; LOAD and READ never overlap load_e/out_e; NOP yields no pin activity.
